plru_eviction_engine: RTL
=========================

// Module: plru_eviction_engine
// PURPOSE
// - Tree pseudo-LRU replacement policy for one cache set. It consumes the cache controller's hit/miss/allocate
//   events and returns a one-hot eviction victim with a ready flag.
// - Sits directly behind the controller's eviction-policy port bundle.
// - Victim search is an iterative root-to-leaf walk of the PLRU tree, one level per clock.
// PARAMETERS
// - NUM_WAYS       512  ways per set; power of two, >=2 (elaboration error otherwise)
// - ADDRESS_WIDTH  32   carried for port-bundle compatibility; unused internally
// - LEVELS (localparam) = $clog2(NUM_WAYS)
// PORTS
// - clk            in   1         clock
// - reset_n        in   1         async active-low reset
// - hit            in   1         cache hit this cycle
// - hitWay         in   NUM_WAYS  one-hot hit way
// - miss           in   1         miss; requests a victim
// - missWay        in   NUM_WAYS  reserved, ignored
// - allocate       in   1         a way is being filled
// - allocateWay    in   NUM_WAYS  one-hot filled way
// - evictionTarget out  NUM_WAYS  one-hot victim; valid only while evictionReady=1
// - evictionReady  out  1         victim valid; held until consumed
// BEHAVIOUR
// - Clocking/reset: single clock clk; reset_n is asynchronous, active-low.
// - Reset state: tree bits (NUM_WAYS-1, heap-indexed) all 0; FSM IDLE; evictionTarget='0; evictionReady=0.
// - Tree layout: node n has children 2n+1 (left, lower ways) and 2n+2 (right).
//   - Leaf node index L maps to way L-(NUM_WAYS-1).
//   - Bit value 0 means the victim lies left; 1 means it lies right.
// - Touch (hit, or allocate) of way w: every node on w's path is set to point away from w. Updates take effect
//   at the next edge.
//   - hit and allocate in the same cycle: both paths are applied; on shared nodes allocate's value wins.
// - One-hot decode: a non-one-hot way vector uses its lowest set bit. An all-zero vector makes the event a no-op.
//   Simulation asserts $onehot0.
// - FSM IDLE -> WALK -> DONE -> IDLE:
//   - IDLE: miss=1 moves to WALK with node index 0 and level 0. miss in any other state is ignored.
//   - WALK: each edge sets node = 2*node+1+treeBit[node]. After LEVELS edges the leaf is registered into
//     evictionTarget, the FSM moves to DONE and evictionReady=1.
//     - Latency: ready rises LEVELS+1 edges after the edge that samples miss.
//     - A hit/allocate during WALK restarts the walk at the root. No snapshot is taken, so the result always
//       reflects the latest tree. Latency is unbounded under back-to-back touches.
//   - DONE: target and ready are held stable.
//     - allocate with allocateWay==target: tree updated, ready=0 and target='0 next edge, FSM to IDLE.
//     - allocate of another way, or a hit on the target way: ready=0 next edge, walk restarts (WALK).
//     - A hit on a non-target way only updates the tree.
// - reset_n low mid-operation: immediate return to the reset state; any pending request is lost.
// CONFIGURATION
// - PLRU_INVALID_FIRST_EN defined:
//   - Adds validMask[NUM_WAYS], reset 0; allocate sets the allocated way's bit.
//   - miss in IDLE with any way invalid: target = lowest invalid way, DONE after 1 edge, no walk.
// - Not defined: no validMask; every miss performs the tree walk.
// STRUCTURE
// - plru_pkg holds:
//   - typedef enum logic[1:0] {IDLE, WALK, DONE} plru_state_e;
//   - function onehot_to_idx (lowest set bit wins);
//   - function path_node(way, level).
// - Sub-module plru_path_update (combinational): takes way index and tree, returns the next tree.
//   Instantiated twice: the hit path, then the allocate path.
// TESTING (NUM_WAYS=8, LEVELS=3)
// - Reset, then miss -> evictionReady=1 after 4 edges, evictionTarget=8'b0000_0001.
// - hit way0, then miss -> target 8'b0001_0000.
// - hits on ways 0,4,2,6 in order, then miss -> target 8'b0000_0010.
// - miss, then hit way3 on the 2nd WALK edge -> walk restarts; ready 4 edges after the hit. Target reflects the
//   updated tree.
// - In DONE with target way1, allocate way1 -> ready=0 next edge, FSM IDLE; a subsequent miss does not pick
//   way1.
// - reset_n low during WALK -> ready=0 and target=0 immediately. With PLRU_INVALID_FIRST_EN: after reset, miss
//   gives target 8'b0000_0001 after 1 edge.

Source files
------------

// File: rtl/plru_pkg.sv
// Shared types and helpers for the tree pseudo-LRU eviction engine.
package plru_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } plru_state_e;

  // Way vectors are zero-extended to this width before decoding.
  localparam int PLRU_MAX_WAYS = 1024;

  // Index of the lowest set bit; 0 for an all-zero vector (callers gate on |vec).
  function automatic int unsigned onehot_to_idx(input logic [PLRU_MAX_WAYS-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = PLRU_MAX_WAYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

  // Heap index of the tree node at depth 'level' on the root-to-leaf path of 'way'.
  function automatic int unsigned path_node(input int unsigned way, input int unsigned level,
                                            input int unsigned levels);
    return ((32'd1 << level) - 32'd1) + (way >> (levels - level));
  endfunction

endpackage

// File: rtl/plru_path_update.sv
// Combinational PLRU touch: points every node on a way's path away from that way.
module plru_path_update
  import plru_pkg::*;
#(
  parameter int NUM_WAYS = 8,
  parameter int LEVELS   = 3
) (
  input  logic                i_en,
  input  logic [LEVELS-1:0]   i_way,
  input  logic [NUM_WAYS-2:0] i_tree,
  output logic [NUM_WAYS-2:0] o_tree
);

  logic [LEVELS-1:0] w_node [LEVELS];
  logic [LEVELS-1:0] w_dir;

  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_level
      assign w_node[gi] = LEVELS'(path_node(32'(i_way), gi, LEVELS));
      // A way in the left subtree (bit 0) makes the node point right, and vice versa.
      assign w_dir[gi]  = ~i_way[LEVELS-1-gi];
    end
  endgenerate

  always_comb begin
    o_tree = i_tree;
    if (i_en) begin
      for (int l = 0; l < LEVELS; l++) begin
        o_tree[w_node[l]] = w_dir[l];
      end
    end
  end

endmodule

// File: rtl/plru_eviction_engine.sv
// Tree pseudo-LRU victim selector for one cache set, walking the tree one level per clock.
// Optional PLRU_INVALID_FIRST_EN: track filled ways and hand out invalid ways before walking.
module plru_eviction_engine
  import plru_pkg::*;
#(
  parameter int unsigned NUM_WAYS      = 512,
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                hit,
  input  logic [NUM_WAYS-1:0] hitWay,
  input  logic                miss,
  input  logic [NUM_WAYS-1:0] missWay,
  input  logic                allocate,
  input  logic [NUM_WAYS-1:0] allocateWay,
  output logic [NUM_WAYS-1:0] evictionTarget,
  output logic                evictionReady
);

  localparam int unsigned LEVELS = $clog2(NUM_WAYS);
  localparam int unsigned NODE_W = LEVELS + 1;
  localparam int unsigned LVL_W  = $clog2(LEVELS + 1);
  localparam logic [NUM_WAYS-1:0] WAY_ONE = {{(NUM_WAYS-1){1'b0}}, 1'b1};

  generate
    if (NUM_WAYS < 2 || (NUM_WAYS & (NUM_WAYS - 1)) != 0 || NUM_WAYS > PLRU_MAX_WAYS) begin : g_bad_cfg
      $error("plru_eviction_engine: NUM_WAYS must be a power of two in [2, PLRU_MAX_WAYS]");
    end
  endgenerate

  plru_state_e         r_state, w_state_next;
  logic [NUM_WAYS-2:0] r_tree, w_tree_hit, w_tree_next;
  logic [NODE_W-1:0]   r_node, w_node_next;
  logic [LVL_W-1:0]    r_level, w_level_next;
  logic [NUM_WAYS-1:0] r_target, w_target_next;
  logic [LEVELS-1:0]   r_target_idx, w_target_idx_next;
  logic                r_ready, w_ready_next;

  logic [PLRU_MAX_WAYS-1:0] w_hit_ext, w_alloc_ext;
  logic [LEVELS-1:0]        w_hit_idx, w_alloc_idx, w_leaf_way, w_inv_idx;
  logic                     w_hit_en, w_alloc_en, w_touch, w_tree_bit, w_inv_pick;
  logic                     w_alloc_is_tgt, w_hit_is_tgt;
  logic [NODE_W-1:0]        w_step_node;
  logic                     w_unused_ports;

  assign w_unused_ports = ^{missWay, 32'(ADDRESS_WIDTH)};

  always_comb begin
    w_hit_ext                  = '0;
    w_alloc_ext                = '0;
    w_hit_ext[NUM_WAYS-1:0]    = hitWay;
    w_alloc_ext[NUM_WAYS-1:0]  = allocateWay;
  end

  assign w_hit_en    = hit & (|hitWay);
  assign w_alloc_en  = allocate & (|allocateWay);
  assign w_touch     = w_hit_en | w_alloc_en;
  assign w_hit_idx   = LEVELS'(onehot_to_idx(w_hit_ext));
  assign w_alloc_idx = LEVELS'(onehot_to_idx(w_alloc_ext));

  assign w_alloc_is_tgt = w_alloc_en && (w_alloc_idx == r_target_idx);
  assign w_hit_is_tgt   = w_hit_en && (w_hit_idx == r_target_idx);

  // Allocate is applied on top of the hit result so it wins on shared nodes.
  plru_path_update #(.NUM_WAYS(NUM_WAYS), .LEVELS(LEVELS)) u_hit_path (
    .i_en   (w_hit_en),
    .i_way  (w_hit_idx),
    .i_tree (r_tree),
    .o_tree (w_tree_hit)
  );

  plru_path_update #(.NUM_WAYS(NUM_WAYS), .LEVELS(LEVELS)) u_alloc_path (
    .i_en   (w_alloc_en),
    .i_way  (w_alloc_idx),
    .i_tree (w_tree_hit),
    .o_tree (w_tree_next)
  );

  assign w_tree_bit  = r_tree[r_node[LEVELS-1:0]];
  assign w_step_node = {r_node[LEVELS-1:0], 1'b1} + NODE_W'(w_tree_bit);
  assign w_leaf_way  = LEVELS'(r_node - NODE_W'(NUM_WAYS - 1));

`ifdef PLRU_INVALID_FIRST_EN
  logic [NUM_WAYS-1:0]      r_valid;
  logic [PLRU_MAX_WAYS-1:0] w_inv_ext;

  always_comb begin
    w_inv_ext                = '0;
    w_inv_ext[NUM_WAYS-1:0]  = ~r_valid;
  end

  assign w_inv_pick = ~(&r_valid);
  assign w_inv_idx  = LEVELS'(onehot_to_idx(w_inv_ext));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (w_alloc_en) begin
      r_valid <= r_valid | (WAY_ONE << w_alloc_idx);
    end
  end
`else
  assign w_inv_pick = 1'b0;
  assign w_inv_idx  = '0;
`endif

  always_comb begin
    w_state_next      = r_state;
    w_node_next       = r_node;
    w_level_next      = r_level;
    w_target_next     = r_target;
    w_target_idx_next = r_target_idx;
    w_ready_next      = r_ready;
    case (r_state)
      IDLE: begin
        if (miss) begin
          if (w_inv_pick) begin
            w_target_next     = WAY_ONE << w_inv_idx;
            w_target_idx_next = w_inv_idx;
            w_ready_next      = 1'b1;
            w_state_next      = DONE;
          end else begin
            w_node_next  = '0;
            w_level_next = '0;
            w_state_next = WALK;
          end
        end
      end
      WALK: begin
        // No snapshot: any touch sends the walk back to the root.
        if (w_touch) begin
          w_node_next  = '0;
          w_level_next = '0;
        end else if (r_level == LVL_W'(LEVELS)) begin
          w_target_next     = WAY_ONE << w_leaf_way;
          w_target_idx_next = w_leaf_way;
          w_ready_next      = 1'b1;
          w_state_next      = DONE;
        end else begin
          w_node_next  = w_step_node;
          w_level_next = r_level + LVL_W'(1);
        end
      end
      DONE: begin
        if (w_alloc_is_tgt) begin
          w_target_next = '0;
          w_ready_next  = 1'b0;
          w_state_next  = IDLE;
        end else if (w_alloc_en || w_hit_is_tgt) begin
          w_target_next = '0;
          w_ready_next  = 1'b0;
          w_node_next   = '0;
          w_level_next  = '0;
          w_state_next  = WALK;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_tree       <= '0;
      r_node       <= '0;
      r_level      <= '0;
      r_target     <= '0;
      r_target_idx <= '0;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tree       <= w_tree_next;
      r_node       <= w_node_next;
      r_level      <= w_level_next;
      r_target     <= w_target_next;
      r_target_idx <= w_target_idx_next;
      r_ready      <= w_ready_next;
    end
  end

  assign evictionTarget = r_target;
  assign evictionReady  = r_ready;

  a_hit_onehot: assert property (@(posedge clk) disable iff (!reset_n) hit |-> $onehot0(hitWay));
  a_alloc_onehot: assert property (@(posedge clk) disable iff (!reset_n) allocate |-> $onehot0(allocateWay));

endmodule
